usb_out_ep_pkt_fifo: RTL and testbench

Packet-framed receive buffer for a USB OUT endpoint (host-to-device data) with a parametrised number of packet buffers. It drains each host packet from the USB core's endpoint data interface into one of NUM_BUFS ring buffers. It presents completed packets, in arrival order, on a valid/ready byte stream with an end-of-packet marker. It sits between the USB protocol core and the serial/DFU consumers and replaces the fixed two-buffer UART adapter.

---
 rtl/usb_out_ep_pkt_fifo_pkg.sv | 13 +
 rtl/usb_out_ep_pkt_mem.sv | 36 +++
 rtl/usb_out_ep_pkt_fifo.sv | 144 ++++++++++++++
 tb/tb_usb_out_ep_pkt_fifo.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_out_ep_pkt_fifo_pkg.sv
// Shared types for the USB OUT endpoint packet FIFO.
// Write-side state encodings and the full-speed packet ceiling.
package usb_out_ep_pkt_fifo_pkg;

  typedef enum logic [1:0] {
    USB_OUT_IDLE    = 2'd0,
    USB_OUT_CAPTURE = 2'd1,
    USB_OUT_COMMIT  = 2'd2
  } usb_out_state_e;

  localparam int USB_MAX_PKT_BYTES = 64;

endpackage

// File: rtl/usb_out_ep_pkt_mem.sv
// Packet storage: NUM_BUFS buffers of DEPTH bytes plus per-buffer length.
// One synchronous write port, one asynchronous (fall-through) read port.
module usb_out_ep_pkt_mem
  import usb_out_ep_pkt_fifo_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NUM_BUFS = 4,
  parameter int AW       = $clog2(DEPTH),
  parameter int BW       = $clog2(NUM_BUFS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [BW-1:0] wr_buf,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          len_we,
  input  logic [BW-1:0] len_buf,
  input  logic [AW:0]   len_val,
  input  logic [BW-1:0] rd_buf,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   rd_len
);

  logic [7:0] mem [NUM_BUFS*DEPTH];
  logic [AW:0] len [NUM_BUFS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_buf, wr_addr}] <= wr_data;
    if (len_we) len[len_buf] <= len_val;
  end

  assign rd_data = mem[{rd_buf, rd_addr}];
  assign rd_len  = len[rd_buf];

endmodule

// File: rtl/usb_out_ep_pkt_fifo.sv
// USB OUT endpoint receive buffer: captures host packets into a ring of
// packet buffers and replays them in order as a byte stream with last.
module usb_out_ep_pkt_fifo
  import usb_out_ep_pkt_fifo_pkg::*;
#(
  parameter int MAX_OUT_PACKET_SIZE = 32,
  parameter int NUM_BUFS            = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       out_ep_req,
  input  logic                       out_ep_grant,
  input  logic                       out_ep_data_avail,
  input  logic                       out_ep_setup,
  output logic                       out_ep_data_get,
  input  logic [7:0]                 out_ep_data,
  output logic                       out_ep_stall,
  input  logic                       out_ep_acked,
  input  logic                       flush,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  output logic                       rd_last,
  input  logic                       rd_ready,
  output logic [$clog2(NUM_BUFS):0]  buf_count,
  output logic                       pkt_dropped
);

  localparam int AW = $clog2(MAX_OUT_PACKET_SIZE);
  localparam int BW = $clog2(NUM_BUFS);
  localparam int CW = BW + 1;
  localparam logic [AW+1:0] PKT_MAX  = (AW+2)'(MAX_OUT_PACKET_SIZE);
  localparam logic [CW-1:0] BUF_FULL = CW'(NUM_BUFS);

  if (MAX_OUT_PACKET_SIZE < 8 || MAX_OUT_PACKET_SIZE > USB_MAX_PKT_BYTES ||
      (MAX_OUT_PACKET_SIZE & (MAX_OUT_PACKET_SIZE - 1)) != 0) begin : g_bad_max
    $error("MAX_OUT_PACKET_SIZE must be a power of 2 in 8..64");
  end
  if (NUM_BUFS < 2 || NUM_BUFS > 8 ||
      (NUM_BUFS & (NUM_BUFS - 1)) != 0) begin : g_bad_bufs
    $error("NUM_BUFS must be a power of 2 in 2..8");
  end

  usb_out_state_e state;
  logic [AW:0]    wr_ptr;
  logic [BW-1:0]  wr_buf;
  logic [BW-1:0]  rd_buf;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    rd_len;
  logic           data_valid;
  logic           setup_seen;
  logic           room;
  logic           drop;
  logic           commit;
  logic           xfer;
  logic           pop;
  logic           unused_acked;

  assign unused_acked = out_ep_acked;

  // Count the byte still in flight so a buffer never over-fills.
  assign room = ({1'b0, wr_ptr} + (AW+2)'(data_valid)) < PKT_MAX;

  // Inside CAPTURE, requests continue only while bytes keep streaming.
  assign out_ep_req = !reset && !flush && (buf_count < BUF_FULL) &&
                      ((state == USB_OUT_IDLE) ||
                       (state == USB_OUT_CAPTURE && data_valid));

  assign out_ep_data_get = out_ep_req & out_ep_grant &
                           out_ep_data_avail & room;
  assign out_ep_stall = 1'b0;

  assign drop   = setup_seen | (data_valid & out_ep_setup);
  assign commit = (state == USB_OUT_COMMIT) && !pkt_dropped;

  assign rd_valid = (buf_count != '0);
  assign rd_last  = rd_valid && ({1'b0, rd_ptr} == rd_len - (AW+1)'(1));
  assign xfer     = rd_valid & rd_ready;
  assign pop      = xfer & rd_last;

  usb_out_ep_pkt_mem #(
    .DEPTH    (MAX_OUT_PACKET_SIZE),
    .NUM_BUFS (NUM_BUFS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (data_valid & !flush & !reset),
    .wr_buf  (wr_buf),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (out_ep_data),
    .len_we  (commit),
    .len_buf (wr_buf),
    .len_val (wr_ptr),
    .rd_buf  (rd_buf),
    .rd_addr (rd_ptr),
    .rd_data (rd_data),
    .rd_len  (rd_len)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state       <= USB_OUT_IDLE;
      wr_ptr      <= '0;
      wr_buf      <= '0;
      rd_buf      <= '0;
      rd_ptr      <= '0;
      buf_count   <= '0;
      data_valid  <= 1'b0;
      setup_seen  <= 1'b0;
      pkt_dropped <= 1'b0;
    end else begin
      data_valid  <= out_ep_data_get;
      pkt_dropped <= 1'b0;
      if (data_valid) wr_ptr <= wr_ptr + (AW+1)'(1);
      unique case (state)
        USB_OUT_IDLE: begin
          setup_seen <= 1'b0;
          if (out_ep_data_get) state <= USB_OUT_CAPTURE;
        end
        USB_OUT_CAPTURE: begin
          setup_seen <= drop;
          if (!out_ep_data_get) begin
            state       <= USB_OUT_COMMIT;
            pkt_dropped <= drop;
          end
        end
        USB_OUT_COMMIT: begin
          wr_ptr <= '0;
          if (!pkt_dropped) wr_buf <= wr_buf + BW'(1);
          state <= USB_OUT_IDLE;
        end
        default: state <= USB_OUT_IDLE;
      endcase
      if (xfer) begin
        if (rd_last) begin
          rd_ptr <= '0;
          rd_buf <= rd_buf + BW'(1);
        end else begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
      buf_count <= buf_count + CW'(commit) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_usb_out_ep_pkt_fifo.sv
// Bench for usb_out_ep_pkt_fifo: core-side packet feeder, cycle tables,
// directed corner sequences and a random run against a packet model.
module tb_usb_out_ep_pkt_fifo;

  localparam int MAX = 32;
  localparam int NB  = 4;
  localparam int CW  = $clog2(NB) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          out_ep_req;
  logic          out_ep_grant = 1'b1;
  logic          out_ep_data_avail = 1'b0;
  logic          out_ep_setup = 1'b0;
  logic          out_ep_data_get;
  logic [7:0]    out_ep_data = 8'h00;
  logic          out_ep_stall;
  logic          out_ep_acked = 1'b0;
  logic          flush = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          rd_ready = 1'b0;
  logic [CW-1:0] buf_count;
  logic          pkt_dropped;

  always #5 clk = ~clk;

  usb_out_ep_pkt_fifo #(
    .MAX_OUT_PACKET_SIZE (MAX),
    .NUM_BUFS            (NB)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .out_ep_req        (out_ep_req),
    .out_ep_grant      (out_ep_grant),
    .out_ep_data_avail (out_ep_data_avail),
    .out_ep_setup      (out_ep_setup),
    .out_ep_data_get   (out_ep_data_get),
    .out_ep_data       (out_ep_data),
    .out_ep_stall      (out_ep_stall),
    .out_ep_acked      (out_ep_acked),
    .flush             (flush),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .rd_last           (rd_last),
    .rd_ready          (rd_ready),
    .buf_count         (buf_count),
    .pkt_dropped       (pkt_dropped)
  );

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         l;
    int         c;
    bit         req;
  } vec_t;

  int total = 0;
  int bad = 0;
  byte unsigned cur[$];
  bit           cur_s[$];
  byte unsigned pend_b[$];
  bit           pend_s[$];
  int           pend_len[$];
  logic [8:0]   got[$];
  logic [8:0]   exp_q[$];
  int drop_cnt = 0;
  int exp_drops = 0;
  int inv_bad = 0;
  int get_cnt = 0;
  bit saw_valid = 0;
  bit rand_gap = 0;
  bit rand_rdy = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // One clock: sample at negedge, then play the USB core after the edge.
  task automatic tick();
    bit g;
    @(negedge clk);
    g = out_ep_data_get;
    if (g) get_cnt++;
    if (rd_valid) saw_valid = 1;
    if (rd_valid && rd_ready) got.push_back({rd_last, rd_data});
    if (pkt_dropped) drop_cnt++;
    if (buf_count > NB || (buf_count == NB && out_ep_req)) inv_bad++;
    @(posedge clk);
    #1;
    out_ep_setup = 1'b0;
    if (g && cur.size() > 0) begin
      out_ep_data  = cur.pop_front();
      out_ep_setup = cur_s.pop_front();
    end else if (!g && cur.size() == 0 && pend_len.size() > 0 &&
                 (!rand_gap || $urandom_range(0, 1) == 1)) begin
      int n;
      n = pend_len.pop_front();
      for (int i = 0; i < n; i++) begin
        cur.push_back(pend_b.pop_front());
        cur_s.push_back(pend_s.pop_front());
      end
    end
    out_ep_data_avail = (cur.size() > 0);
    if (rand_rdy) rd_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Model: host packets split into MAX-byte chunks; SETUP chunks vanish.
  task automatic send(input int len, input bit setup, input int base,
                      input bit model);
    pend_len.push_back(len);
    for (int j = 0; j < len; j++) begin
      pend_b.push_back(8'(base + j));
      pend_s.push_back(setup);
    end
    if (model) begin
      for (int off = 0; off < len; off += MAX) begin
        int n;
        n = (len - off > MAX) ? MAX : len - off;
        if (setup) exp_drops++;
        else for (int j = 0; j < n; j++)
          exp_q.push_back({(j == n - 1), 8'(base + off + j)});
      end
    end
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((pend_len.size() > 0 || cur.size() > 0 || buf_count != 0 ||
            got.size() < exp_q.size()) && c < budget) begin
      tick();
      c++;
    end
    chk("drain in budget", int'(c < budget), 1);
    repeat (4) tick();
  endtask

  task automatic cmp_stream(input string name);
    int n;
    n = exp_q.size();
    chk({name, " length"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s byte %0d: got %h expected %h",
                 name, i, got[i], exp_q[i]);
        break;
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  vec_t tbl[13];
  int gaps;

  initial begin
    tbl[0]  = '{0, 8'h00, 0, 0, 1};
    tbl[1]  = '{0, 8'h00, 0, 0, 1};
    tbl[2]  = '{0, 8'h00, 0, 0, 1};
    tbl[3]  = '{0, 8'h00, 0, 0, 1};
    tbl[4]  = '{0, 8'h00, 0, 0, 1};
    tbl[5]  = '{0, 8'h00, 0, 0, 1};
    tbl[6]  = '{0, 8'h00, 0, 0, 0};
    tbl[7]  = '{1, 8'h11, 0, 1, 1};
    tbl[8]  = '{1, 8'h12, 0, 1, 1};
    tbl[9]  = '{1, 8'h13, 0, 1, 1};
    tbl[10] = '{1, 8'h14, 0, 1, 1};
    tbl[11] = '{1, 8'h15, 1, 1, 1};
    tbl[12] = '{0, 8'h00, 0, 0, 1};

    repeat (2) tick();
    #1;
    chk("reset req", out_ep_req, 0);
    chk("reset get", out_ep_data_get, 0);
    chk("reset stall", out_ep_stall, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_last", rd_last, 0);
    chk("reset buf_count", buf_count, 0);
    chk("reset dropped", pkt_dropped, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("req after reset", out_ep_req, 1);
    repeat (3) tick();

    rd_ready = 1'b1;
    send(5, 0, 'h11, 1);
    tick();
    for (int k = 0; k < 13; k++) begin
      #1;
      chk($sformatf("t%0d rd_valid", k), rd_valid, tbl[k].v);
      chk($sformatf("t%0d buf_count", k), buf_count, tbl[k].c);
      chk($sformatf("t%0d req", k), out_ep_req, tbl[k].req);
      if (tbl[k].v) begin
        chk($sformatf("t%0d rd_data", k), rd_data, tbl[k].d);
        chk($sformatf("t%0d rd_last", k), rd_last, tbl[k].l);
      end
      tick();
    end
    cmp_stream("single");

    rd_ready = 1'b0;
    for (int p = 0; p < 6; p++) send(8, 0, p * 8, 1);
    repeat (150) tick();
    #1;
    chk("full buf_count", buf_count, NB);
    chk("full req", out_ep_req, 0);
    chk("full rd_valid", rd_valid, 1);
    rd_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (!rd_valid) gaps++;
      tick();
    end
    chk("full drain gaps", gaps, 0);
    drain(400);
    cmp_stream("six packets");

    send(40, 0, 'hC0, 1);
    drain(400);
    cmp_stream("split 40");

    saw_valid = 0;
    drop_cnt = 0;
    exp_drops = 0;
    send(8, 1, 'hE0, 1);
    repeat (30) tick();
    chk("setup drop pulses", drop_cnt, exp_drops);
    chk("setup buf_count", buf_count, 0);
    chk("setup rd_valid seen", saw_valid, 0);

    rd_ready = 1'b0;
    send(3, 0, 'h20, 1);
    send(3, 0, 'h30, 1);
    repeat (30) tick();
    #1;
    chk("pre-concurrent count", buf_count, 2);
    send(6, 0, 'hA0, 1);
    tick();
    for (int k = 0; k < 9; k++) begin
      rd_ready = (k >= 5 && k <= 7);
      #1;
      if (k == 7) begin
        chk("concurrent rd_last", rd_last, 1);
        chk("concurrent count", buf_count, 2);
      end
      tick();
    end
    #1;
    chk("after concurrent count", buf_count, 2);
    rd_ready = 1'b1;
    drain(400);
    cmp_stream("concurrent");

    rd_ready = 1'b0;
    send(4, 0, 'h40, 0);
    repeat (15) tick();
    #1;
    chk("pre-flush count", buf_count, 1);
    send(8, 0, 'h50, 0);
    get_cnt = 0;
    for (int c = 0; c < 40 && get_cnt < 3; c++) tick();
    chk("flush reached byte 3", get_cnt, 3);
    flush = 1'b1;
    cur.delete();
    cur_s.delete();
    out_ep_data_avail = 1'b0;
    #1;
    chk("flush req", out_ep_req, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush buf_count", buf_count, 0);
    chk("flush rd_valid", rd_valid, 0);
    got.delete();
    exp_q.delete();
    rd_ready = 1'b1;
    send(4, 0, 'h60, 1);
    drain(400);
    cmp_stream("after flush");

    drop_cnt = 0;
    exp_drops = 0;
    inv_bad = 0;
    rand_gap = 1;
    rand_rdy = 1;
    for (int p = 0; p < 40; p++)
      send($urandom_range(0, 45), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 255)), 1);
    drain(20000);
    cmp_stream("random");
    chk("random drops", drop_cnt, exp_drops);
    chk("full invariant", inv_bad, 0);
    rand_rdy = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
